// File: rtl/edge_setup.sv
// edge_setup: per-frame setup of edge functions for two triangles, with one shared serial multiplier and a per-line step.
// Optional build macro EDGE_SETUP_SAT_EN: line-0 results and line steps saturate to 20 bits instead of wrapping.
module edge_setup #(
  parameter int TRIG_Y   = 480,
  parameter int H_ACTIVE = 640
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic signed [19:0] x_screen_v0,
  input  logic signed [19:0] x_screen_v1,
  input  logic signed [19:0] x_screen_v2,
  input  logic signed [19:0] x_screen_v3,
  input  logic signed [19:0] y_screen_v0,
  input  logic signed [19:0] y_screen_v1,
  input  logic signed [19:0] y_screen_v2,
  input  logic signed [19:0] y_screen_v3,
  output logic signed [19:0] e0_init_t1,
  output logic signed [19:0] e1_init_t1,
  output logic signed [19:0] e2_init_t1,
  output logic signed [19:0] e0_init_t2,
  output logic signed [19:0] e1_init_t2,
  output logic signed [19:0] e2_init_t2,
  output logic               busy
);

  localparam logic [9:0] TRIG_Y_L   = 10'(TRIG_Y);
  localparam logic [9:0] H_ACTIVE_L = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACTIVE_L = 10'd480;
  localparam logic [4:0] LAST_BIT   = 5'd19;
  localparam logic [3:0] LAST_PROD  = 4'd11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    SUM  = 2'd2
  } state_t;

  // Edge k runs from vertex vert_a(k) to vert_b(k); k=0..2 is t1, k=3..5 is t2.
  function automatic logic [1:0] vert_a(input logic [2:0] e);
    case (e)
      3'd1:    vert_a = 2'd1;
      3'd2:    vert_a = 2'd2;
      3'd4:    vert_a = 2'd2;
      3'd5:    vert_a = 2'd3;
      default: vert_a = 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] vert_b(input logic [2:0] e);
    case (e)
      3'd0:    vert_b = 2'd1;
      3'd1:    vert_b = 2'd2;
      3'd3:    vert_b = 2'd2;
      3'd4:    vert_b = 2'd3;
      default: vert_b = 2'd0;
    endcase
  endfunction

`ifdef EDGE_SETUP_SAT_EN
  function automatic logic signed [19:0] sat20(input logic signed [41:0] v);
    if (v > 42'sd524287)
      sat20 = 20'sh7ffff;
    else if (v < -42'sd524288)
      sat20 = 20'sh80000;
    else
      sat20 = v[19:0];
  endfunction
`endif

  state_t             state_reg;
  state_t             state_next;
  logic signed [19:0] live_x [4];
  logic signed [19:0] live_y [4];
  logic signed [19:0] snap_x [4];
  logic signed [19:0] snap_y [4];
  logic signed [19:0] edge_out [6];
  logic [4:0]         bit_cnt_reg;
  logic [3:0]         prod_cnt_reg;
  logic signed [41:0] mul_acc_reg;
  logic signed [41:0] mul_acc_next;
  logic signed [41:0] mul_term;
  logic signed [19:0] mul_m;
  logic signed [20:0] mul_c;
  logic [2:0]         prod_edge;
  logic [1:0]         va;
  logic [1:0]         vb;
  logic               trig;
  logic               prod_done;
  logic               mul_done;
  logic               sum_wr;
  logic               step_en;

  assign live_x[0] = x_screen_v0;
  assign live_x[1] = x_screen_v1;
  assign live_x[2] = x_screen_v2;
  assign live_x[3] = x_screen_v3;
  assign live_y[0] = y_screen_v0;
  assign live_y[1] = y_screen_v1;
  assign live_y[2] = y_screen_v2;
  assign live_y[3] = y_screen_v3;

  assign trig      = (y == TRIG_Y_L) && (x == 10'd0);
  assign prod_done = (state_reg == MUL) && (bit_cnt_reg == 5'd0);
  assign mul_done  = prod_done && (prod_cnt_reg == LAST_PROD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // A trigger always wins: it restarts the setup from a fresh snapshot.
  always_comb begin
    state_next = state_reg;
    if (trig) begin
      state_next = MUL;
    end else begin
      case (state_reg)
        MUL:     if (mul_done) state_next = SUM;
        SUM:     state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy    = (state_reg != IDLE);
    sum_wr  = (state_reg == SUM) && !trig;
    step_en = (y < V_ACTIVE_L) && (x == H_ACTIVE_L) && (state_reg == IDLE);
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_vert
      logic signed [19:0] sx_reg;
      logic signed [19:0] sy_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sx_reg <= '0;
          sy_reg <= '0;
        end else if (trig) begin
          sx_reg <= live_x[gi];
          sy_reg <= live_y[gi];
        end
      end

      assign snap_x[gi] = sx_reg;
      assign snap_y[gi] = sy_reg;
    end
  endgenerate

  // Product 2k is xa*(yb-ya), product 2k+1 is ya*(xb-xa), both for edge k.
  // The multiplier walks the 20-bit coordinate MSB first (Horner form); bit 19 carries negative weight.
  always_comb begin
    prod_edge = prod_cnt_reg[3:1];
    va        = vert_a(prod_edge);
    vb        = vert_b(prod_edge);
    if (prod_cnt_reg[0]) begin
      mul_m = snap_y[va];
      mul_c = {snap_x[vb][19], snap_x[vb]} - {snap_x[va][19], snap_x[va]};
    end else begin
      mul_m = snap_x[va];
      mul_c = {snap_y[vb][19], snap_y[vb]} - {snap_y[va][19], snap_y[va]};
    end
    mul_term = '0;
    if (mul_m[bit_cnt_reg])
      mul_term = (bit_cnt_reg == LAST_BIT) ? -42'(mul_c) : 42'(mul_c);
    mul_acc_next = (mul_acc_reg <<< 1) + mul_term;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_reg  <= '0;
      prod_cnt_reg <= '0;
      mul_acc_reg  <= '0;
    end else if (trig) begin
      bit_cnt_reg  <= LAST_BIT;
      prod_cnt_reg <= '0;
      mul_acc_reg  <= '0;
    end else if (state_reg == MUL) begin
      if (bit_cnt_reg == 5'd0) begin
        bit_cnt_reg  <= LAST_BIT;
        prod_cnt_reg <= (prod_cnt_reg == LAST_PROD) ? 4'd0 : prod_cnt_reg + 4'd1;
        mul_acc_reg  <= '0;
      end else begin
        bit_cnt_reg <= bit_cnt_reg - 5'd1;
        mul_acc_reg <= mul_acc_next;
      end
    end
  end

  generate
    for (gi = 0; gi < 6; gi++) begin : g_edge
      localparam logic [1:0] VA = vert_a(3'(gi));
      localparam logic [1:0] VB = vert_b(3'(gi));

      logic signed [41:0] edge_acc_reg;
      logic signed [19:0] out_reg;
      logic signed [19:0] line0;
      logic signed [19:0] stepped;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          edge_acc_reg <= '0;
        else if (trig)
          edge_acc_reg <= '0;
        else if (prod_done && (prod_edge == 3'(gi)))
          edge_acc_reg <= prod_cnt_reg[0] ? edge_acc_reg + mul_acc_next
                                          : edge_acc_reg - mul_acc_next;
      end

`ifdef EDGE_SETUP_SAT_EN
      logic signed [20:0] delta;
      logic signed [21:0] step_sum;
      assign delta    = {snap_x[VA][19], snap_x[VA]} - {snap_x[VB][19], snap_x[VB]};
      assign step_sum = 22'(out_reg) + 22'(delta);
      assign line0    = sat20(edge_acc_reg);
      assign stepped  = sat20(42'(step_sum));
`else
      logic signed [19:0] delta;
      assign delta   = snap_x[VA] - snap_x[VB];
      assign line0   = edge_acc_reg[19:0];
      assign stepped = out_reg + delta;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          out_reg <= '0;
        else if (sum_wr)
          out_reg <= line0;
        else if (step_en)
          out_reg <= stepped;
      end

      assign edge_out[gi] = out_reg;
    end
  endgenerate

  assign e0_init_t1 = edge_out[0];
  assign e1_init_t1 = edge_out[1];
  assign e2_init_t1 = edge_out[2];
  assign e0_init_t2 = edge_out[3];
  assign e1_init_t2 = edge_out[4];
  assign e2_init_t2 = edge_out[5];

endmodule

// File: tb/tb_edge_setup.sv
// Directed bench for edge_setup: a small frame model pushes expected outputs to a queue, drained and checked at each step.
module tb_edge_setup;
  localparam int H_ACTIVE = 640;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [9:0]         x = 10'd1;
  logic [9:0]         y = 10'd600;
  logic signed [19:0] x_screen_v0, x_screen_v1, x_screen_v2, x_screen_v3;
  logic signed [19:0] y_screen_v0, y_screen_v1, y_screen_v2, y_screen_v3;
  logic signed [19:0] e0_init_t1, e1_init_t1, e2_init_t1;
  logic signed [19:0] e0_init_t2, e1_init_t2, e2_init_t2;
  logic               busy;

  edge_setup #(.TRIG_Y(480), .H_ACTIVE(H_ACTIVE)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .x_screen_v0(x_screen_v0), .x_screen_v1(x_screen_v1),
    .x_screen_v2(x_screen_v2), .x_screen_v3(x_screen_v3),
    .y_screen_v0(y_screen_v0), .y_screen_v1(y_screen_v1),
    .y_screen_v2(y_screen_v2), .y_screen_v3(y_screen_v3),
    .e0_init_t1(e0_init_t1), .e1_init_t1(e1_init_t1), .e2_init_t1(e2_init_t1),
    .e0_init_t2(e0_init_t2), .e1_init_t2(e1_init_t2), .e2_init_t2(e2_init_t2),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [19:0] val;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass = 0;
  longint      vx[4], vy[4], sx[4], sy[4];
  logic [19:0] mdl[6];
  int          ea[6] = '{0, 1, 2, 0, 2, 3};
  int          eb[6] = '{1, 2, 0, 2, 3, 0};
  logic [19:0] aux_obs;

  function automatic logic [19:0] clamp20(longint v);
    longint r;
    r = v;
`ifdef EDGE_SETUP_SAT_EN
    if (r > 524287) r = 524287;
    else if (r < -524288) r = -524288;
`endif
    return r[19:0];
  endfunction

  function automatic logic [19:0] line0(int e);
    longint xa, ya, xb, yb;
    xa = sx[ea[e]]; ya = sy[ea[e]];
    xb = sx[eb[e]]; yb = sy[eb[e]];
    return clamp20(-xa * (yb - ya) + ya * (xb - xa));
  endfunction

  function automatic logic [19:0] observe(int sel);
    case (sel)
      0: return e0_init_t1;
      1: return e1_init_t1;
      2: return e2_init_t1;
      3: return e0_init_t2;
      4: return e1_init_t2;
      5: return e2_init_t2;
      6: return {19'd0, busy};
      default: return aux_obs;
    endcase
  endfunction

  task automatic tick(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(string tag, int sel, logic [19:0] val);
    exp_t it;
    it.tag = tag; it.sel = sel; it.val = val;
    sb.push_back(it);
  endtask

  task automatic push_outs(string tag);
    for (int e = 0; e < 6; e++) push($sformatf("%s_out%0d", tag, e), e, mdl[e]);
  endtask

  task automatic drain();
    exp_t        it;
    logic [19:0] obs;
    while (sb.size() > 0) begin
      it  = sb.pop_front();
      obs = observe(it.sel);
      n_checks++;
      assert (obs === it.val) begin
        n_pass++;
      end else begin
        $error("FAIL %s: observed %0d (0x%05h) expected %0d (0x%05h)",
               it.tag, $signed(obs), obs, $signed(it.val), it.val);
      end
    end
  endtask

  task automatic set_v(int i, longint xx, longint yy);
    vx[i] = xx; vy[i] = yy;
  endtask

  task automatic drive_verts();
    x_screen_v0 = 20'(vx[0]); y_screen_v0 = 20'(vy[0]);
    x_screen_v1 = 20'(vx[1]); y_screen_v1 = 20'(vy[1]);
    x_screen_v2 = 20'(vx[2]); y_screen_v2 = 20'(vy[2]);
    x_screen_v3 = 20'(vx[3]); y_screen_v3 = 20'(vy[3]);
  endtask

  task automatic square();
    set_v(0, 10, 10); set_v(1, 100, 10); set_v(2, 10, 100); set_v(3, 100, 100);
    drive_verts();
  endtask

  task automatic trigger();
    y = 10'd480; x = 10'd0;
    tick();
    x = 10'd1;
    for (int i = 0; i < 4; i++) begin sx[i] = vx[i]; sy[i] = vy[i]; end
  endtask

  task automatic finish_setup(string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tick();
      n++;
    end
    aux_obs = (n > 0 && n <= 300) ? 20'd1 : 20'd0;
    push({tag, "_setup_len"}, 7, 20'd1);
    push({tag, "_busy_low"}, 6, 20'd0);
    for (int e = 0; e < 6; e++) mdl[e] = line0(e);
    push_outs(tag);
  endtask

  task automatic step_line(int line);
    y = 10'(line); x = 10'(H_ACTIVE);
    tick();
    x = 10'd1; y = 10'd600;
    if (line < 480)
      for (int e = 0; e < 6; e++)
        mdl[e] = clamp20(longint'($signed(mdl[e])) + (sx[ea[e]] - sx[eb[e]]));
  endtask

  initial begin
    square();
    rst_n = 1'b0;
    tick(3);
    for (int e = 0; e < 6; e++) mdl[e] = '0;
    push_outs("reset");
    push("reset_busy", 6, 20'd0);
    drain();
    rst_n = 1'b1;
    tick(2);

    // Square frame: line-0 values, then two line steps.
    trigger();
    push("busy_rise", 6, 20'd1);
    drain();
    finish_setup("square");
    push("sq_e0_t1", 0, 20'(900));
    push("sq_e1_t1", 1, 20'(-9900));
    push("sq_e2_t1", 2, 20'(900));
    drain();
    step_line(0);
    push("y0_e0_t1", 0, 20'(810));
    push("y0_e1_t1", 1, 20'(-9810));
    push("y0_e2_t1", 2, 20'(900));
    push_outs("y0");
    drain();
    step_line(1);
    push("y1_e0_t1", 0, 20'(720));
    push_outs("y1");
    drain();

    // Step position outside the active lines is ignored.
    y = 10'd500; x = 10'(H_ACTIVE);
    tick(5);
    x = 10'd1; y = 10'd600;
    push_outs("hold_y500");
    drain();

    // VS changes mid-frame do not disturb the running frame's steps.
    y = 10'd481;
    set_v(0, 20, 20);
    drive_verts();
    tick(2);
    step_line(2);
    push("old_delta_e0_t1", 0, 20'(630));
    push_outs("y2");
    drain();
    trigger();
    finish_setup("newv0");
    push("newv0_e0_t1", 0, 20'(1800));
    drain();

    // Asynchronous reset during MUL, then a clean setup.
    square();
    trigger();
    tick(50);
    push("busy_mid", 6, 20'd1);
    drain();
    #2 rst_n = 1'b0;
    #1;
    for (int e = 0; e < 6; e++) mdl[e] = '0;
    push_outs("async_rst");
    push("async_rst_busy", 6, 20'd0);
    drain();
    tick(2);
    rst_n = 1'b1;
    tick(2);
    trigger();
    finish_setup("after_rst");
    push("ar_e0_t1", 0, 20'(900));
    push("ar_e1_t1", 1, 20'(-9900));
    push("ar_e2_t1", 2, 20'(900));
    drain();

    // Retrigger while busy: old outputs held, new snapshot wins.
    set_v(0, 5, 3); set_v(1, 50, 7); set_v(2, 20, 60); set_v(3, 70, 40);
    drive_verts();
    trigger();
    tick(30);
    push_outs("restart_hold");
    push("restart_busy", 6, 20'd1);
    drain();
    set_v(0, -30, 12); set_v(1, 45, -8); set_v(2, 7, 90); set_v(3, 120, 33);
    drive_verts();
    trigger();
    finish_setup("restart");
    drain();
    step_line(0);
    push_outs("restart_y0");
    drain();

    // Large coordinates: wrap or saturate depending on the build.
    set_v(0, -262144, 0); set_v(1, 0, 0); set_v(2, 0, 262143); set_v(3, 0, 0);
    drive_verts();
    trigger();
    finish_setup("big");
    push("big_e1_t1", 1, 20'd0);
`ifdef EDGE_SETUP_SAT_EN
    push("big_e2_t1", 2, 20'h80000);
`else
    push("big_e2_t1", 2, 20'h40000);
`endif
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
